// File: rtl/pong_pkg.sv
// Shared Pong geometry constants and the paddle position type.
package pong_pkg;

   localparam int unsigned SCREEN_W   = 32'd640;
   localparam int unsigned SCREEN_H   = 32'd480;
   localparam int unsigned PADDLE_H   = 32'd64;
   localparam int unsigned PADDLE_Y_W = 32'd10;
   localparam int unsigned BALL_POS_W = 32'd11;

   typedef logic [PADDLE_Y_W-1:0] paddle_y_t;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stable-time debouncer for one raw push-button.
// The debounced level changes only after the synchronised input differs for DEBOUNCE_CYC cycles.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYC = 32'd250000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_i,
   output logic btn_o
);

   localparam int unsigned   CW       = (DEBOUNCE_CYC > 32'd1) ? $clog2(DEBOUNCE_CYC) : 32'd1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 32'd1);

   logic          sync1_q;
   logic          sync2_q;
   logic          db_q;
   logic          db_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Stable counter: restarts whenever the synchronised level agrees with the accepted one.
   always_comb begin
      db_d  = db_q;
      cnt_d = '0;
      if (sync2_q == db_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         db_d  = sync2_q;
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1'b1);
      end
   end

   // Synchroniser, counter and accepted level registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         db_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         db_q    <= db_d;
         cnt_q   <= cnt_d;
      end
   end

   assign btn_o = db_q;

endmodule

// File: rtl/paddle_ctrl.sv
// Paddle controller: debounced up/down buttons move the paddle top edge once per movement tick.
// Define PADDLE_ACCEL_EN to double the step after 8 consecutive same-direction moves.
module paddle_ctrl #(
   parameter int unsigned SCREEN_H     = pong_pkg::SCREEN_H,
   parameter int unsigned PADDLE_H     = pong_pkg::PADDLE_H,
   parameter int unsigned STEP         = 32'd4,
   parameter int unsigned TICK_DIV     = 32'd416667,
   parameter int unsigned DEBOUNCE_CYC = 32'd250000,
   parameter int unsigned RESET_Y      = (SCREEN_H - PADDLE_H) / 32'd2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                btn_up,
   input  logic                btn_down,
   input  logic                freeze,
   input  logic                recentre,
   output pong_pkg::paddle_y_t paddle_y,
   output logic                moving
);

   import pong_pkg::*;

   localparam int unsigned   TW        = (TICK_DIV > 32'd1) ? $clog2(TICK_DIV) : 32'd1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 32'd1);
   localparam logic [10:0]   YMAX_X    = 11'(SCREEN_H - PADDLE_H);
   localparam logic [10:0]   STEP_X    = 11'(STEP);
   localparam paddle_y_t     RESET_Y_V = paddle_y_t'(RESET_Y);

   logic          up_db_s;
   logic          dn_db_s;
   logic          up_s;
   logic          dn_s;
   logic          move_tick_s;
   logic [TW-1:0] tick_q;
   logic [TW-1:0] tick_d;
   logic [10:0]   y_x_s;
   logic [10:0]   step_s;
   logic [10:0]   y_mv_s;
   paddle_y_t     paddle_y_q;
   paddle_y_t     paddle_y_d;
   logic          moving_q;
   logic          moving_d;

`ifdef PADDLE_ACCEL_EN
   localparam logic [10:0] STEP2_X  = 11'(2 * STEP);
   localparam logic [3:0]  RUN_FAST = 4'd8;

   logic [3:0] run_q;
   logic [3:0] run_d;
   logic       run_dn_q;
   logic       run_dn_d;
`endif

   btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_up (
      .clk   (clk),
      .reset (reset),
      .btn_i (btn_up),
      .btn_o (up_db_s)
   );

   btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_dn (
      .clk   (clk),
      .reset (reset),
      .btn_i (btn_down),
      .btn_o (dn_db_s)
   );

   // Free-running movement tick divider; freeze does not stop it.
   always_comb begin
      move_tick_s = (tick_q == TICK_LAST);
      if (move_tick_s) begin
         tick_d = '0;
      end else begin
         tick_d = tick_q + TW'(1'b1);
      end
   end

   // Candidate position for this tick, computed in 11 bits and clamped to [0, YMAX].
   always_comb begin
      up_s   = up_db_s & ~dn_db_s;
      dn_s   = dn_db_s & ~up_db_s;
      y_x_s  = {1'b0, paddle_y_q};
      step_s = STEP_X;
`ifdef PADDLE_ACCEL_EN
      if ((run_q == RUN_FAST) && (run_dn_q == dn_s) && (up_s || dn_s)) begin
         step_s = STEP2_X;
      end else begin
         step_s = STEP_X;
      end
`endif
      if (up_s) begin
         if (y_x_s < step_s) begin
            y_mv_s = '0;
         end else begin
            y_mv_s = y_x_s - step_s;
         end
      end else if (dn_s) begin
         if (y_x_s > (YMAX_X - step_s)) begin
            y_mv_s = YMAX_X;
         end else begin
            y_mv_s = y_x_s + step_s;
         end
      end else begin
         y_mv_s = y_x_s;
      end
   end

   // Position update: recentre beats everything, then freeze, then the tick move.
   always_comb begin
      paddle_y_d = paddle_y_q;
      moving_d   = 1'b0;
      if (recentre) begin
         paddle_y_d = RESET_Y_V;
         moving_d   = 1'b0;
      end else if (move_tick_s && !freeze) begin
         paddle_y_d = paddle_y_t'(y_mv_s);
         moving_d   = (y_mv_s != y_x_s);
      end else begin
         paddle_y_d = paddle_y_q;
         moving_d   = 1'b0;
      end
   end

   // Tick counter, position and moving-flag registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         tick_q     <= '0;
         paddle_y_q <= RESET_Y_V;
         moving_q   <= 1'b0;
      end else begin
         tick_q     <= tick_d;
         paddle_y_q <= paddle_y_d;
         moving_q   <= moving_d;
      end
   end

`ifdef PADDLE_ACCEL_EN
   // Run length of consecutive same-direction move ticks, saturating at RUN_FAST.
   always_comb begin
      run_d    = run_q;
      run_dn_d = run_dn_q;
      if (recentre) begin
         run_d = '0;
      end else if (move_tick_s) begin
         if (freeze || !(up_s || dn_s)) begin
            run_d = '0;
         end else if ((run_q != 4'd0) && (run_dn_q == dn_s)) begin
            run_d = (run_q == RUN_FAST) ? RUN_FAST : (run_q + 4'd1);
         end else begin
            run_d    = 4'd1;
            run_dn_d = dn_s;
         end
      end else begin
         run_d = run_q;
      end
   end

   // Accelerator run-count registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         run_q    <= '0;
         run_dn_q <= 1'b0;
      end else begin
         run_q    <= run_d;
         run_dn_q <= run_dn_d;
      end
   end
`endif

   assign paddle_y = paddle_y_q;
   assign moving   = moving_q;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed self-checking bench for paddle_ctrl with fast tick/debounce settings.
// Honours PADDLE_ACCEL_EN for the acceleration expectations.
module tb_paddle_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       btn_up = 1'b0;
   logic       btn_down = 1'b0;
   logic       freeze = 1'b0;
   logic       recentre = 1'b0;
   logic [9:0] paddle_y;
   logic       moving;

   int tests_run = 0;
   int tests_failed = 0;
   int n;

   paddle_ctrl #(
      .STEP         (32'd4),
      .TICK_DIV     (32'd4),
      .DEBOUNCE_CYC (32'd3)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .btn_up   (btn_up),
      .btn_down (btn_down),
      .freeze   (freeze),
      .recentre (recentre),
      .paddle_y (paddle_y),
      .moving   (moving)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int got, input int exp);
      tests_run++;
      if (got != exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   // Cycles until paddle_y changes; -1 if it does not within budget.
   task automatic wait_change(input int budget, output int cnt);
      logic [9:0] old;
      old = paddle_y;
      cnt = -1;
      for (int i = 1; i <= budget; i++) begin
         cyc(1);
         if (paddle_y != old) begin
            cnt = i;
            break;
         end
      end
   endtask

   task automatic wait_until(input int target, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (int'(paddle_y) == target) break;
         cyc(1);
      end
   endtask

   // Position must stay at exp_y and moving must stay low for k cycles.
   task automatic quiet(input string tag, input int k, input int exp_y);
      int bad;
      bad = 0;
      for (int i = 0; i < k; i++) begin
         cyc(1);
         if ((int'(paddle_y) != exp_y) || moving) bad++;
      end
      check_eq(tag, bad, 0);
   endtask

   initial begin
      // Reset and idle
      cyc(3);
      reset = 1'b0;
      cyc(1);
      check_eq("reset_y", int'(paddle_y), 208);
      check_eq("reset_moving", int'(moving), 0);
      quiet("idle40", 40, 208);

      // Glitches of 1 and 2 cycles are rejected
      btn_up = 1'b1; cyc(1); btn_up = 1'b0;
      quiet("glitch1", 12, 208);
      btn_up = 1'b1; cyc(2); btn_up = 1'b0;
      quiet("glitch2", 12, 208);

      // Steady press: first move after sync+debounce, then every 4 cycles
      btn_up = 1'b1;
      wait_change(12, n);
      check_eq("first_move_latency", int'((n >= 6) && (n <= 9)), 1);
      check_eq("first_move_y", int'(paddle_y), 204);
      check_eq("first_move_moving", int'(moving), 1);
      wait_change(8, n);
      check_eq("tick_period", n, 4);
      check_eq("second_move_y", int'(paddle_y), 200);
      cyc(1);
      check_eq("moving_pulse_width", int'(moving), 0);

      // Top clamp
      wait_until(8, 300);
      check_eq("reach_8", int'(paddle_y), 8);
      wait_change(8, n);
      check_eq("y_4", int'(paddle_y), 4);
      wait_change(8, n);
      check_eq("y_0", int'(paddle_y), 0);
      check_eq("y_0_moving", int'(moving), 1);
      quiet("clamp_top", 12, 0);

      // Bottom clamp
      btn_up = 1'b0; btn_down = 1'b1;
      wait_until(412, 600);
      check_eq("reach_412", int'(paddle_y), 412);
      wait_change(8, n);
      check_eq("y_416", int'(paddle_y), 416);
      check_eq("y_416_tick", n, 4);
      quiet("clamp_bot", 12, 416);

      // Release right after a tick: one more tick still moves (debounce), then hold
      btn_down = 1'b0; btn_up = 1'b1;
      wait_until(400, 100);
      check_eq("reach_400", int'(paddle_y), 400);
      btn_up = 1'b0;
      cyc(4);
      check_eq("release_last_move", int'(paddle_y), 396);
      quiet("release_hold", 12, 396);

      // Both buttons, then freeze with down held
      btn_up = 1'b1; btn_down = 1'b1;
      quiet("both_held", 20, 396);
      freeze = 1'b1; btn_up = 1'b0;
      quiet("freeze_hold", 20, 396);

      // Recentre while frozen at 0
      freeze = 1'b0; btn_down = 1'b0; btn_up = 1'b1;
      wait_until(0, 600);
      check_eq("reach_0", int'(paddle_y), 0);
      freeze = 1'b1;
      cyc(2);
      recentre = 1'b1; cyc(1); recentre = 1'b0;
      check_eq("recentre_y", int'(paddle_y), 208);
      check_eq("recentre_moving", int'(moving), 0);
      quiet("frozen_after_recentre", 8, 208);
      freeze = 1'b0;
      wait_change(8, n);
      check_eq("unfreeze_latency", int'((n >= 1) && (n <= 4)), 1);
      check_eq("unfreeze_y", int'(paddle_y), 204);

      // Reset mid-move with btn_up held: buttons must re-debounce
      reset = 1'b1; cyc(1); reset = 1'b0;
      check_eq("midreset_y", int'(paddle_y), 208);
      check_eq("midreset_moving", int'(moving), 0);
      cyc(4);
      check_eq("midreset_db_cleared", int'(paddle_y), 208);
      cyc(4);
      check_eq("midreset_first_move", int'(paddle_y), 204);
      check_eq("midreset_first_moving", int'(moving), 1);

      // Long down run from 208 (doubles after 8 moves when acceleration is built in)
      btn_up = 1'b0; btn_down = 1'b1;
      reset = 1'b1; cyc(1); reset = 1'b0;
      cyc(36);
      check_eq("run_8_moves", int'(paddle_y), 240);
      cyc(4);
`ifdef PADDLE_ACCEL_EN
      check_eq("run_9th", int'(paddle_y), 248);
      btn_down = 1'b0;
      cyc(4);
      check_eq("run_10th", int'(paddle_y), 256);
      cyc(4);
      check_eq("run_release_hold", int'(paddle_y), 256);
      btn_down = 1'b1;
      cyc(8);
      check_eq("run_repress_step", int'(paddle_y), 260);
`else
      check_eq("run_9th", int'(paddle_y), 244);
      btn_down = 1'b0;
      cyc(4);
      check_eq("run_10th", int'(paddle_y), 248);
      cyc(4);
      check_eq("run_release_hold", int'(paddle_y), 248);
      btn_down = 1'b1;
      cyc(8);
      check_eq("run_repress_step", int'(paddle_y), 252);
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
